// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the requester handshakes, the shared response bus and the
//   external ALU connection of alu_share_arbiter.
//   Modports:
//     slave  - the arbiter: takes requests and ALU results; drives
//              req_ready, the rsp_* bus and the ALU operands/opcode.
//     master - the environment: the requesters plus the ALU.
//   Signals:
//     req_valid[1:0] / req_ready[1:0]  per-requester request handshake
//     req_a0, req_b0, req_ctrl0        requester 0 operands and opcode
//     req_a1, req_b1, req_ctrl1        requester 1 operands and opcode
//     rsp_valid[1:0] / rsp_ready[1:0]  per-requester response handshake
//     rsp_res, rsp_zero                shared result bus and zero flag
//     alu_rs1, alu_rs2, alu_ctrl       operands and opcode to the ALU
//     alu_res, alu_zero                combinational ALU result and zero flag
interface alu_share_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    logic [CTRL_W-1:0] req_ctrl0;
    logic [CTRL_W-1:0] req_ctrl1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_res;
    logic              rsp_zero;
    logic [DATA_W-1:0] alu_rs1;
    logic [DATA_W-1:0] alu_rs2;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_ctrl0, req_ctrl1,
        input  rsp_ready, alu_res, alu_zero,
        output req_ready, rsp_valid, rsp_res, rsp_zero, alu_rs1, alu_rs2, alu_ctrl
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_ctrl0, req_ctrl1,
        output rsp_ready, alu_res, alu_zero,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, alu_rs1, alu_rs2, alu_ctrl
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one ALU between two requesters. The winning request's operands
//   and opcode are registered, drive the ALU for one cycle (EXEC), and the
//   captured result is returned only to the requester that issued it (RESP).
//   Accept in cycle N, ALU evaluates in N+1, rsp_valid from N+2.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - alu_share_arbiter_if.slave (request/response handshakes, ALU port)
//   Configuration:
//     ALU_ARB_RR_EN - when defined, contended grants alternate using rr_ptr;
//                     when undefined, requester 0 always wins contention.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
) (
    input logic                clk,
    input logic                rst,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              zero_q;

    logic              grant;
    logic              can_accept;
    logic [1:0]        req_ready;
    logic              hs;
    logic              contended;

    assign contended = (bus.req_valid == 2'b11);

`ifdef ALU_ARB_RR_EN
    logic rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (hs && contended) begin
            // Loser of this contention gets priority next time.
            rr_ptr_q <= ~grant;
        end
    end
`endif

    always_comb begin
        grant = 1'b0;
        if (bus.req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (contended) begin
`ifdef ALU_ARB_RR_EN
            grant = rr_ptr_q;
`else
            grant = 1'b0;
`endif
        end
    end

    // A new request may be taken while the current response retires.
    assign can_accept = (state_q == StIdle) ||
                        ((state_q == StResp) && bus.rsp_ready[owner_q]);

    always_comb begin
        req_ready = 2'b00;
        if (can_accept && (bus.req_valid != 2'b00)) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign hs = |(bus.req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (hs) state_d = StExec;
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready[owner_q]) state_d = hs ? StExec : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                owner_q <= grant;
                a_q     <= grant ? bus.req_a1    : bus.req_a0;
                b_q     <= grant ? bus.req_b1    : bus.req_b0;
                ctrl_q  <= grant ? bus.req_ctrl1 : bus.req_ctrl0;
            end
            if (state_q == StExec) begin
                res_q  <= bus.alu_res;
                zero_q <= bus.alu_zero;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == StResp) ? (2'b01 << owner_q) : 2'b00;
    assign bus.rsp_res   = res_q;
    assign bus.rsp_zero  = zero_q;
    // Operand registers only change on acceptance, so the ALU inputs hold
    // their last values outside EXEC.
    assign bus.alu_rs1   = a_q;
    assign bus.alu_rs2   = b_q;
    assign bus.alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Randomized and directed stimulus against a transaction-level model of
//   the arbiter; expected responses go into a scoreboard queue that a
//   separate monitor drains whenever the DUT presents a response.
module tb_alu_share_arbiter;

    localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr = 4'd3,
                           OpXor = 4'd4, OpSll = 4'd5, OpSrl = 4'd6, OpSra = 4'd7,
                           OpSlt = 4'd8, OpSltu = 4'd9;

    logic clk;
    logic rst;

    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(4)) bus ();

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpSll:   return a << b[4:0];
            OpSrl:   return a >> b[4:0];
            OpSra:   return 32'($signed(a) >>> b[4:0]);
            OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OpSltu:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU sitting behind the arbiter.
    assign bus.alu_res  = alu_ref(bus.alu_ctrl, bus.alu_rs1, bus.alu_rs2);
    assign bus.alu_zero = (bus.alu_res == 32'd0);

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Transaction-level model state.
    bit         model_valid = 0;
    bit         inflight = 0;
    int         infl_owner = 0;
    int         infl_t = 0;
    int         pref = 0;
    int         cyc = 0;
    logic [1:0] last_ready;

    task automatic drive(input logic [1:0] v, input logic [3:0] c0, input logic [31:0] a0,
                         input logic [31:0] b0, input logic [3:0] c1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [1:0] rr);
        bus.req_valid = v;
        bus.req_ctrl0 = c0;
        bus.req_a0    = a0;
        bus.req_b0    = b0;
        bus.req_ctrl1 = c1;
        bus.req_a1    = a1;
        bus.req_b1    = b1;
        bus.rsp_ready = rr;
    endtask

    task automatic idle(input logic [1:0] rr);
        drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, rr);
    endtask

    // One clock: check the handshake outputs against the model, then advance
    // the model across the rising edge. Returns 1 time unit after the edge.
    task automatic cycle();
        logic [1:0]  v, rr, exp_ready, exp_rv;
        bit          vis, completing, can_acc, contended;
        int          win;
        logic [31:0] a, b, r;
        logic [3:0]  c;
        #1;
        v          = bus.req_valid;
        rr         = bus.rsp_ready;
        vis        = inflight && (cyc >= infl_t + 2);
        completing = vis && rr[infl_owner];
        can_acc    = !inflight || completing;
        contended  = (v == 2'b11);
        win        = contended ? pref : (v[1] ? 1 : 0);
        exp_ready  = (can_acc && v != 2'b00) ? (2'b01 << win) : 2'b00;
        exp_rv     = vis ? (2'b01 << infl_owner) : 2'b00;
        a = (win == 1) ? bus.req_a1 : bus.req_a0;
        b = (win == 1) ? bus.req_b1 : bus.req_b0;
        c = (win == 1) ? bus.req_ctrl1 : bus.req_ctrl0;
        last_ready = bus.req_ready;
        if (model_valid) begin
            chk("req_ready", {62'd0, bus.req_ready}, {62'd0, exp_ready});
            chk("rsp_valid_timing", {62'd0, bus.rsp_valid}, {62'd0, exp_rv});
        end
        @(posedge clk);
        if (rst) begin
            inflight    = 0;
            pref        = 0;
            sb.delete();
            model_valid = 1;
        end else if (model_valid) begin
            if (completing) inflight = 0;
            if (exp_ready != 2'b00) begin
                r = alu_ref(c, a, b);
                sb.push_back('{owner: win, res: r, zero: (r == 32'd0)});
                inflight   = 1;
                infl_owner = win;
                infl_t     = cyc;
`ifdef ALU_ARB_RR_EN
                if (contended) pref = 1 - win;
`endif
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2'b00);
        cycle();
        rst = 1'b0;
    endtask

    // Monitor: compare every presented response with the scoreboard head;
    // pop when the owner accepts it.
    exp_t mon_e;
    always @(negedge clk) begin
        if (model_valid && bus.rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {62'd0, bus.rsp_valid}, 64'd0);
            end else begin
                mon_e = sb[0];
                chk("rsp_owner", {62'd0, bus.rsp_valid}, {62'd0, 2'b01 << mon_e.owner});
                chk("rsp_res", {32'd0, bus.rsp_res}, {32'd0, mon_e.res});
                chk("rsp_zero", {63'd0, bus.rsp_zero}, {63'd0, mon_e.zero});
                if (bus.rsp_ready[mon_e.owner]) void'(sb.pop_front());
            end
        end
    end

    int g[$];
    int gc[$];
    int exp_g[4];

    initial begin
        rst = 1'b1;
        idle(2'b00);
        cycle();
        cycle();
        rst = 1'b0;

        // ADD 5+7 from requester 0.
        drive(2'b01, OpAdd, 32'd5, 32'd7, OpAdd, 32'd0, 32'd0, 2'b11);
        cycle();
        chk("t1_ready", {62'd0, last_ready}, 64'd1);
        idle(2'b11);
        cycle();
        chk("t1_rsp_valid", {62'd0, bus.rsp_valid}, 64'd1);
        chk("t1_rsp_res", {32'd0, bus.rsp_res}, 64'd12);
        chk("t1_rsp_zero", {63'd0, bus.rsp_zero}, 64'd0);
        cycle();

        // SUB 9-9 from requester 1, response stalled 3 cycles; requester 0 waits.
        drive(2'b10, OpAdd, 32'd0, 32'd0, OpSub, 32'd9, 32'd9, 2'b00);
        cycle();
        chk("t2_ready", {62'd0, last_ready}, 64'd2);
        idle(2'b00);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, OpAdd, 32'd1, 32'd1, OpAdd, 32'd0, 32'd0, 2'b01);
            chk("t2_hold_valid", {62'd0, bus.rsp_valid}, 64'd2);
            chk("t2_hold_res", {32'd0, bus.rsp_res}, 64'd0);
            chk("t2_hold_zero", {63'd0, bus.rsp_zero}, 64'd1);
            cycle();
            chk("t2_no_grant", {62'd0, last_ready}, 64'd0);
        end
        idle(2'b10);
        cycle();
        cycle();

        // Contention: both valid with immediate rsp_ready.
        do_reset();
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, OpAdd, i, 32'd100, OpXor, i, 32'd3, 2'b11);
            cycle();
            if (last_ready != 2'b00) begin
                g.push_back(last_ready == 2'b10 ? 1 : 0);
                gc.push_back(i);
            end
        end
        idle(2'b11);
        cycle();
        cycle();
        chk("t3_grant_count", g.size(), 64'd4);
        for (int i = 0; i < g.size() && i < 4; i++) begin
            chk("t3_grant_order", g[i], exp_g[i]);
            if (i > 0) chk("t3_grant_spacing", gc[i] - gc[i-1], 64'd2);
        end

        // SRA from requester 0, then SLT from requester 1.
        drive(2'b01, OpSra, 32'h8000_0000, 32'd4, OpAdd, 32'd0, 32'd0, 2'b11);
        cycle();
        drive(2'b10, OpAdd, 32'd0, 32'd0, OpSlt, 32'hFFFF_FFFF, 32'd1, 2'b11);
        cycle();
        chk("t4_sra_valid", {62'd0, bus.rsp_valid}, 64'd1);
        chk("t4_sra_res", {32'd0, bus.rsp_res}, 64'hF800_0000);
        cycle();
        chk("t4_slt_ready", {62'd0, last_ready}, 64'd2);
        idle(2'b11);
        cycle();
        chk("t4_slt_valid", {62'd0, bus.rsp_valid}, 64'd2);
        chk("t4_slt_res", {32'd0, bus.rsp_res}, 64'd1);
        cycle();

        // Reset during the EXEC cycle of an OR.
        drive(2'b01, OpOr, 32'h0000_00F0, 32'h0000_000F, OpAdd, 32'd0, 32'd0, 2'b11);
        cycle();
        rst = 1'b1;
        idle(2'b11);
        cycle();
        rst = 1'b0;
        chk("t5_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
        chk("t5_rsp_res", {32'd0, bus.rsp_res}, 64'd0);
        chk("t5_rsp_zero", {63'd0, bus.rsp_zero}, 64'd0);
        chk("t5_alu_rs1", {32'd0, bus.alu_rs1}, 64'd0);
        chk("t5_alu_rs2", {32'd0, bus.alu_rs2}, 64'd0);
        chk("t5_alu_ctrl", {60'd0, bus.alu_ctrl}, 64'd0);
        chk("t5_req_ready", {62'd0, bus.req_ready}, 64'd0);
        cycle();
        cycle();
        drive(2'b10, OpAdd, 32'd0, 32'd0, OpAnd, 32'hFF00_FF00, 32'h0F0F_0F0F, 2'b11);
        cycle();
        chk("t5_after_ready", {62'd0, last_ready}, 64'd2);
        idle(2'b11);
        cycle();
        cycle();

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)});
            cycle();
        end
        rst = 1'b0;
        idle(2'b11);
        for (int i = 0; i < 5; i++) cycle();
        chk("drain_empty", sb.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares a single ALU instance between two requesters (e.g. the core's execute stage and a debug/CSR path) with valid/ready handshakes on both request and response sides. It arbitrates, registers the winning operands and opcode, drives the external ALU for exactly one cycle, captures the result, and returns it only to the requester that issued it. It sits between the requesters and one ALU instance, and the `alu_encoding` package defines the opcodes it forwards.

## Interface
- `DATA_W`, 32, operand/result width; must match the ALU.
- `CTRL_W`, 4, opcode width; must match `alu_encoding`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  per-requester request valid.
- `req_ready[1:0]`  out  2  per-requester request accept.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DATA_W each  operands for requester 0 / 1.
- `req_ctrl0`, `req_ctrl1`  in  CTRL_W each  ALU opcode for requester 0 / 1.
- `rsp_valid[1:0]`  out  2  per-requester response valid.
- `rsp_ready[1:0]`  in  2  per-requester response accept.
- `rsp_res`  out  DATA_W  result, shared bus, meaningful for whichever `rsp_valid` bit is set.
- `rsp_zero`  out  1  zero flag accompanying `rsp_res`.
- `alu_rs1`, `alu_rs2`  out  DATA_W  operands to the ALU.
- `alu_ctrl`  out  CTRL_W  opcode to the ALU.
- `alu_res`  in  DATA_W  ALU result (combinational from the ALU).
- `alu_zero`  in  1  ALU zero flag.

## Operation
- FSM has three states:
  - IDLE: no transaction in flight.
  - EXEC: registered operands and opcode drive the ALU.
  - RESP: result is held and the owner's `rsp_valid` is high.
- Grant is computed from `req_valid` and the priority pointer `rr_ptr`.
  - If only one requester is valid, it wins.
  - If both are valid, `rr_ptr` wins; the pointer then flips to the other requester.
- `req_ready[i]` is high only for the granted requester, and only when the arbiter can accept:
  - state is IDLE, or
  - state is RESP and the current response completes in this cycle (`rsp_ready[owner]`=1).
- Request handshake (`req_valid[i] & req_ready[i]`):
  - latches operands, opcode and `owner`=i into registers;
  - next state is EXEC.
- EXEC lasts exactly one cycle:
  - `alu_rs1/alu_rs2/alu_ctrl` come from the registers;
  - `alu_res`/`alu_zero` are captured into `res_q`/`zero_q`;
  - next state is RESP.
- RESP:
  - `rsp_valid[owner]`=1, `rsp_res`=`res_q`, `rsp_zero`=`zero_q`;
  - these values hold stable until `rsp_ready[owner]`=1;
  - `rsp_ready` of the non-owner is ignored.
- RESP exit:
  - response completes and a new request is accepted in the same cycle → EXEC;
  - response completes with no new request → IDLE.
- Outside EXEC, the ALU inputs keep their last registered values; no new values are driven.
- Opcodes pass through unchecked. An undefined code yields whatever the ALU returns (0 in the current ALU).

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0;
  - `req_ready`=0, `rsp_valid`=0, `rsp_res`=0, `rsp_zero`=0;
  - `alu_rs1`=0, `alu_rs2`=0, `alu_ctrl`=0.
- Latency: request accepted in cycle N; ALU evaluates in N+1; `rsp_valid` is high from N+2.
- Throughput is one operation per 2 cycles when responses are consumed immediately.
- `req_ready` is combinational on `req_valid`, `rr_ptr`, state and `rsp_ready`. `rsp_*` are purely registered.
- A requester whose valid drops before grant loses nothing; there is no pending memory.
- Reset mid-operation: the in-flight transaction is discarded, no response is issued, and `rr_ptr` returns to 0.
- Both requesters valid with `rr_ptr`=1: requester 1 is granted, `rr_ptr`→0 on that handshake.

## Configuration
- `ALU_ARB_RR_EN`:
  - defined: round-robin as described; `rr_ptr` toggles on every contended grant.
  - undefined: fixed priority, requester 0 always wins contention; `rr_ptr` is not implemented.

## Test plan
- Reset, then only requester 0 issues ALU_ADD a=5, b=7 → `req_ready[0]`=1 in cycle 0; `rsp_valid[0]` in cycle 2 with `rsp_res`=12, `rsp_zero`=0.
- Requester 1 issues ALU_SUB a=9, b=9 while `rsp_ready[1]` is held low 3 cycles → `rsp_valid[1]` stays high with `rsp_res`=0, `rsp_zero`=1 stable for 3 cycles; no new grant occurs.
- Both valid for 4 consecutive operations, with immediate `rsp_ready` → grants 0,1,0,1 with `ALU_ARB_RR_EN`, or 0,0,0,0 without it; new grant each 2 cycles.
- ALU_SRA a=0x80000000, b=4 from requester 0 immediately followed by ALU_SLT a=0xFFFFFFFF, b=1 from requester 1:
  - results are 0xF8000000 then 1;
  - `rsp_valid[1]` is never high during requester 0's response.
- Assert `rst` in the EXEC cycle of an ALU_OR → no `rsp_valid` afterward; all outputs 0 next cycle; next request is served normally.
